out_mux_ser: RTL and testbench
==============================

// Module: out_mux_ser
// PURPOSE
//  Parametrised output serializer for the multi-section IIR datapath. Accepts one
//  frame of NUM_CH wide signed accumulator results with a valid/ready handshake.
//  Emits one channel per clock as an OUT_W-bit sample. Each sample is rounded
//  (optional) and saturated (optional). Sits between the filter accumulators and
//  the narrow output bus. Adds a frame handshake, channel tagging and overflow
//  flags to the fixed 3-channel rotating output mux.
// PARAMETERS
//  NUM_CH    3   channels per frame (>=2)
//  IN_W      36  input sample width, signed two's complement
//  OUT_W     11  output sample width, signed
//  FRAC_LSB  24  input bit index that maps to output LSB; FRAC_LSB+OUT_W <= IN_W
//  RND_EN    1   1: round half up using bit FRAC_LSB-1; 0: truncate (forced 0 if FRAC_LSB=0)
//  SAT_EN    1   1: clamp to OUT_W signed range; 0: wrap (keep low OUT_W bits)
//  CH_W      $clog2(NUM_CH)  derived, not overridable
// PORTS
//  clk       in   1             rising-edge clock
//  reset     in   1             synchronous, active-high
//  in_valid  in   1             frame present on in_data
//  in_data   in   NUM_CH*IN_W   packed frame, ch0 in bits [IN_W-1:0]
//  in_ready  out  1             block can accept a frame this cycle
//  out_data  out  OUT_W         converted sample, signed
//  out_valid out  1             out_data/out_ch valid this cycle
//  out_ch    out  CH_W          channel index of out_data
//  out_sof   out  1             high with channel 0 of each frame
//  sat_flag  out  1             current sample was clamped (SAT_EN=1 only)
//  ovf_err   out  1             1-cycle pulse: frame offered while in_ready=0, frame dropped
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, frame regs=0. All registered outputs are 0 in the
//   cycle after reset is sampled high. in_ready=0 while reset is high.
//  FSM IDLE: in_ready=1. On in_valid&in_ready, capture in_data and go to SEND with idx=0.
//  FSM SEND: each cycle register conv(frame[idx]) onto out_data, with out_valid=1,
//   out_ch=idx and out_sof=(idx==0); then idx++.
//   - in_ready=1 only when idx==NUM_CH-1 (last channel).
//   - Accept at that edge: reload frame, idx=0, stay in SEND. The next frame
//     starts with no bubble.
//   - No accept at that edge: go to IDLE.
//  Latency: frame accepted at edge T -> ch k on outputs during cycle T+1+k.
//  No output backpressure; output stream is fixed-rate once started.
//  in_valid while in_ready=0: frame ignored, registered ovf_err=1 next cycle.
//   The current frame is unaffected.
//  Reset mid-frame: remaining channels discarded; out_valid=0 next cycle.
//  conv(x):
//   - v = (x >>> FRAC_LSB) + (RND_EN ? x[FRAC_LSB-1] : 0), evaluated in
//     IN_W-FRAC_LSB+1 bits signed, so a rounding carry never wraps.
//   - SAT_EN=1: v > 2^(OUT_W-1)-1 -> max, v < -2^(OUT_W-1) -> min, with
//     sat_flag=1 registered with the sample. Otherwise out = v[OUT_W-1:0].
//   - SAT_EN=0: out = v[OUT_W-1:0]; sat_flag stays 0.
//   - Ties round toward +inf (-3.5 -> -3).
//  sat_flag, out_sof and out_ch are 0 whenever out_valid=0.
//  out_data holds its last value when out_valid=0, except after reset, when it is 0.
// TESTING (defaults unless noted)
//  1 Reset 2 cycles mid-SEND -> next cycle out_valid=0, out_data=0, ovf_err=0;
//    in_ready=1 the cycle after release.
//  2 Frame {1<<23, 5<<24, -(7<<23)} at T -> out_data 1,5,-3 at T+1..T+3;
//    out_ch 0,1,2; out_sof only at T+1.
//  3 Frame {2000<<24, -(2000<<24), (1023<<24)|(1<<23)} -> 1023,-1024,1023,
//    sat_flag 1,1,1.
//  4 Same as 3 with SAT_EN=0 -> -48, 48, -1024; sat_flag 0.
//  5 Frames A at T and B at T+3 -> out_valid high T+1..T+6 continuously;
//    out_sof at T+1 and T+4.
//  6 Frame A at T, in_valid again at T+1 -> ovf_err=1 at T+2 only; A output intact;
//    second frame never appears.

Source files
------------

// File: rtl/out_mux_ser.sv
// Frame-in, sample-out serializer: captures NUM_CH wide accumulator results and
// emits one rounded/saturated OUT_W-bit sample per clock, tagged with its channel.
module out_mux_ser #(
    parameter int NUM_CH   = 3,
    parameter int IN_W     = 36,
    parameter int OUT_W    = 11,
    parameter int FRAC_LSB = 24,
    parameter int RND_EN   = 1,
    parameter int SAT_EN   = 1,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [NUM_CH*IN_W-1:0]   in_data,
    output logic                     in_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_sof,
    output logic                     sat_flag,
    output logic                     ovf_err
);

    // One extra bit above the shifted value so the rounding carry cannot wrap.
    localparam int VW = IN_W - FRAC_LSB + 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_reg;
    logic [CH_W-1:0]   idx_reg;
    logic [IN_W-1:0]   frame_reg [NUM_CH];
    logic [OUT_W-1:0]  conv_data [NUM_CH];
    logic              conv_sat  [NUM_CH];
    logic              accept;

    assign in_ready = !reset && ((state_reg == IDLE) || (idx_reg == LAST_CH));
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_conv
            logic [VW-1:0] shifted;
            logic [VW-1:0] v;
            logic          rnd;

            assign shifted = {frame_reg[gi][IN_W-1], frame_reg[gi][IN_W-1:FRAC_LSB]};

            if (RND_EN != 0 && FRAC_LSB > 0) begin : g_rnd
                assign rnd = frame_reg[gi][FRAC_LSB-1];
            end else begin : g_trunc
                assign rnd = 1'b0;
            end

            assign v = shifted + VW'(rnd);

            if (SAT_EN != 0) begin : g_sat
                logic ovf;
                // In range only when every bit from the output sign bit upward agrees.
                assign ovf = !((&v[VW-1:OUT_W-1]) || !(|v[VW-1:OUT_W-1]));
                assign conv_sat[gi]  = ovf;
                assign conv_data[gi] = !ovf     ? v[OUT_W-1:0] :
                                       v[VW-1]  ? {1'b1, {(OUT_W-1){1'b0}}} :
                                                  {1'b0, {(OUT_W-1){1'b1}}};
            end else begin : g_wrap
                assign conv_sat[gi]  = 1'b0;
                assign conv_data[gi] = v[OUT_W-1:0];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_sof   <= 1'b0;
            sat_flag  <= 1'b0;
            ovf_err   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                frame_reg[i] <= '0;
            end
        end else begin
            ovf_err <= in_valid && !in_ready;
            case (state_reg)
                IDLE: begin
                    out_valid <= 1'b0;
                    out_ch    <= '0;
                    out_sof   <= 1'b0;
                    sat_flag  <= 1'b0;
                    if (accept) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            frame_reg[i] <= in_data[i*IN_W +: IN_W];
                        end
                        idx_reg   <= '0;
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    out_data  <= conv_data[idx_reg];
                    out_valid <= 1'b1;
                    out_ch    <= idx_reg;
                    out_sof   <= (idx_reg == '0);
                    sat_flag  <= conv_sat[idx_reg];
                    if (idx_reg == LAST_CH) begin
                        idx_reg <= '0;
                        // Reloading on the last channel keeps back-to-back frames gapless.
                        if (accept) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                frame_reg[i] <= in_data[i*IN_W +: IN_W];
                            end
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_mux_ser.sv
// Bench for out_mux_ser: table-driven frames plus random frames, checked through a
// scoreboard against a saturating instance and a wrapping instance.
module tb_out_mux_ser;

    localparam int NUM_CH   = 3;
    localparam int IN_W     = 36;
    localparam int OUT_W    = 11;
    localparam int FRAC_LSB = 24;
    localparam int CH_W     = 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   in_valid = 1'b0;
    logic [NUM_CH*IN_W-1:0] in_data = '0;

    logic                   rdy_s, val_s, sof_s, sat_s, ovf_s;
    logic [OUT_W-1:0]       data_s;
    logic [CH_W-1:0]        ch_s;
    logic                   rdy_w, val_w, sof_w, sat_w, ovf_w;
    logic [OUT_W-1:0]       data_w;
    logic [CH_W-1:0]        ch_w;

    out_mux_ser #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .FRAC_LSB(FRAC_LSB),
                  .RND_EN(1), .SAT_EN(1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_s), .out_data(data_s), .out_valid(val_s), .out_ch(ch_s),
        .out_sof(sof_s), .sat_flag(sat_s), .ovf_err(ovf_s));

    out_mux_ser #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .FRAC_LSB(FRAC_LSB),
                  .RND_EN(1), .SAT_EN(0)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_w), .out_data(data_w), .out_valid(val_w), .out_ch(ch_w),
        .out_sof(sof_w), .sat_flag(sat_w), .ovf_err(ovf_w));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][35:0] d;
        logic [2:0][10:0] es;
        logic [2:0]       sf;
        logic [2:0][10:0] ew;
    } vec_t;

    typedef struct packed {
        logic [10:0] es;
        logic        sf;
        logic [10:0] ew;
        logic [1:0]  ch;
        logic        sof;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    vec_t tbl [5];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   valid_cnt = 0, sof_cnt = 0, first_v = 0, last_v = 0;
    int   acc_a, acc_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [35:0] fx(input longint v);
        return v[35:0];
    endfunction

    function automatic logic [10:0] o(input int v);
        return v[10:0];
    endfunction

    function automatic vec_t mkv(input longint d0, d1, d2, input int e0, e1, e2,
                                 input logic [2:0] sf, input int w0, w1, w2);
        vec_t v;
        v.d[0] = fx(d0);  v.d[1] = fx(d1);  v.d[2] = fx(d2);
        v.es[0] = o(e0);  v.es[1] = o(e1);  v.es[2] = o(e2);
        v.sf = sf;
        v.ew[0] = o(w0);  v.ew[1] = o(w1);  v.ew[2] = o(w2);
        return v;
    endfunction

    // Reference conversion in plain integer arithmetic.
    function automatic void model(input logic [35:0] x, output logic [10:0] s,
                                  output logic sf, output logic [10:0] w);
        longint xv, q;
        xv = {{28{x[35]}}, x};
        q = (xv >>> 24) + ((xv >>> 23) & 64'sd1);
        sf = 1'b0;
        if (q > 64'sd1023) begin s = o(1023); sf = 1'b1; end
        else if (q < -64'sd1024) begin s = o(-1024); sf = 1'b1; end
        else s = q[10:0];
        w = q[10:0];
    endfunction

    task automatic send_frame(input vec_t v, output int acc);
        bit   ok = 1'b0;
        exp_t x;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (rdy_s) ok = 1'b1;
        end
        if (!ok) check("ready_timeout", rdy_s, 1);
        in_valid = 1'b1;
        in_data  = v.d;
        for (int k = 0; k < 3; k++) begin
            x.es = v.es[k]; x.sf = v.sf[k]; x.ew = v.ew[k];
            x.ch = 2'(k);   x.sof = (k == 0);
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0;
        $display("in  cyc=%0d frame %h %h %h", acc, v.d[0], v.d[1], v.d[2]);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (val_s) begin
                if (valid_cnt == 0) first_v = cyc;
                valid_cnt++;
                last_v = cyc;
                if (sof_s) sof_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_output", val_s, 0);
                end else begin
                    e = sb.pop_front();
                    $display("out cyc=%0d ch=%0d sof=%0d data=%0d sat=%0d wrap=%0d",
                             cyc, ch_s, sof_s, $signed(data_s), sat_s, $signed(data_w));
                    check("data_sat", data_s, e.es);
                    check("sat_flag", sat_s, e.sf);
                    check("out_ch", ch_s, e.ch);
                    check("out_sof", sof_s, e.sof);
                    check("valid_wrap", val_w, 1);
                    check("data_wrap", data_w, e.ew);
                    check("sat_flag_wrap", sat_w, 0);
                end
            end else begin
                check("idle_tags_zero", {sat_s, sof_s, ch_s}, 0);
                check("idle_valid_wrap", val_w, 0);
            end
        end
    end

    initial begin
        logic [35:0] x;
        logic [31:0] u0, u1;
        vec_t        rv;
        int          dummy;

        tbl[0] = mkv(64'sd1 <<< 23, 64'sd5 <<< 24, -(64'sd7 <<< 23),
                     1, 5, -3, 3'b000, 1, 5, -3);
        tbl[1] = mkv(64'sd2000 <<< 24, -(64'sd2000 <<< 24), (64'sd1023 <<< 24) + (64'sd1 <<< 23),
                     1023, -1024, 1023, 3'b111, -48, 48, -1024);
        tbl[2] = mkv(64'sd1023 <<< 24, -(64'sd1024 <<< 24), (64'sd1 <<< 23) - 1,
                     1023, -1024, 0, 3'b000, 1023, -1024, 0);
        tbl[3] = mkv(-(64'sd1 <<< 23), -(64'sd1024 <<< 24) - (64'sd1 <<< 23) - 1, 64'sh7_FFFF_FFFF,
                     0, -1024, 1023, 3'b110, 0, 1023, 0);
        tbl[4] = mkv(-(64'sd1 <<< 35), (64'sd1023 <<< 24) + (64'sd1 <<< 23) - 1,
                     -(64'sd1 <<< 24) - (64'sd1 <<< 23),
                     -1024, 1023, -1, 3'b001, 0, 1023, -1);

        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", val_s, 0);
        check("rst_data", data_s, 0);
        check("rst_tags", {sat_s, sof_s, ch_s}, 0);
        check("rst_ovf", ovf_s, 0);
        check("rst_ready_low", rdy_s, 0);
        #1 reset = 1'b0;
        #1 check("ready_after_release", rdy_s, 1);

        // Reset for two cycles while a frame is mid-send
        send_frame(tbl[0], dummy);
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_valid", val_s, 0);
        check("midrst_data", data_s, 0);
        check("midrst_ovf", ovf_s, 0);
        #1 reset = 1'b0;
        #1 check("midrst_ready", rdy_s, 1);

        // Table frames, back to back
        for (int i = 0; i < 5; i++) send_frame(tbl[i], dummy);
        repeat (5) @(posedge clk);

        // Two frames with no bubble between them
        @(negedge clk);
        #1;
        valid_cnt = 0; sof_cnt = 0;
        send_frame(tbl[2], acc_a);
        send_frame(tbl[4], acc_b);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        check("b2b_accept_gap", acc_b - acc_a, 3);
        check("b2b_valid_cnt", valid_cnt, 6);
        check("b2b_sof_cnt", sof_cnt, 2);
        check("b2b_valid_span", last_v - first_v, 5);

        // Frame offered while busy is dropped and flagged for one cycle
        send_frame(tbl[1], dummy);
        in_valid = 1'b1;
        in_data  = {36'h0_0300_0000, 36'h0_0300_0000, 36'h0_0300_0000};
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("ovf_pulse", ovf_s, 1);
        check("ovf_pulse_wrap", ovf_w, 1);
        @(negedge clk);
        check("ovf_clear", ovf_s, 0);
        repeat (5) @(posedge clk);

        // Random frames against the reference model, with occasional idle gaps
        for (int f = 0; f < 10; f++) begin
            for (int k = 0; k < 3; k++) begin
                u0 = $urandom;
                u1 = $urandom;
                x = {u1[3:0], u0};
                x = $signed(x) >>> $urandom_range(0, 12);
                rv.d[k] = x;
                model(x, rv.es[k], rv.sf[k], rv.ew[k]);
            end
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            send_frame(rv, dummy);
        end

        repeat (6) @(posedge clk);
        @(negedge clk);
        #1 check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
